// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
package reg_arb_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 5;

  // Register map
  localparam int unsigned ADDR_EN_OUT_7_0  = 0;
  localparam int unsigned ADDR_EN_OUT_15_8 = 1;
  localparam int unsigned ADDR_EN_PWM_7_0  = 2;
  localparam int unsigned ADDR_EN_PWM_15_8 = 3;
  localparam int unsigned ADDR_PWM_DUTY    = 4;

  // Grant / write source ids
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    HOLDOFF
  } state_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request bus for the two requesters (A: SPI decoder, B: sequencer).
// master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) ();

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready
  );

endinterface

// File: rtl/reg_arb_bank.sv
// Control register bank: address decode and storage for the configurable
// registers. Out-of-range write addresses match no register and are dropped.
// Optional readback port enabled by REG_READBACK_EN.
module reg_arb_bank import reg_arb_pkg::*; #(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] regs_o [NUM_REGS]
`ifdef REG_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
`endif
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: a write lands only on the register whose index matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_i == ADDR_W'(i)) begin
          regs_q[i] <= data_i;
        end
      end
    end
  end

  assign regs_o = regs_q;

`ifdef REG_READBACK_EN
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rd_data_q;

  // Readback select; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_mux = regs_q[i];
      end
    end
  end

  // Registered readback; samples pre-write contents when a write is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux;
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the SPI-configurable control registers.
// Requester A (SPI decoder) and B (sequencer) share one write path; each grant
// runs IDLE -> WRITE -> HOLDOFF, committing exactly one register write.
// Optional readback port enabled by REG_READBACK_EN.
module reg_write_arbiter import reg_arb_pkg::*; #(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  reg_write_arbiter_if.slave bus,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_src,
  output logic              err_addr,
  output logic              busy
`ifdef REG_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);

  localparam logic [ADDR_W-1:0] NumRegsA = ADDR_W'(NUM_REGS);

  state_e            state_q;
  logic              ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              a_ready_q;
  logic              b_ready_q;
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_src_q;
  logic              err_q;
  logic              busy_q;

  logic              grant_src;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Winner selection: a lone requester wins; on contention the pointer decides.
  always_comb begin
    grant_src = SRC_A;
    if (bus.b_valid && (!bus.a_valid || (ptr_q == SRC_B))) begin
      grant_src = SRC_B;
    end
    win_addr = (grant_src == SRC_B) ? bus.b_addr : bus.a_addr;
    win_data = (grant_src == SRC_B) ? bus.b_data : bus.a_data;
  end

  // Arbiter FSM; pulse outputs are set on the IDLE->WRITE edge so they are
  // high exactly during the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= SRC_A;
      addr_q      <= '0;
      data_q      <= '0;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_src_q    <= SRC_A;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.a_valid || bus.b_valid) begin
            addr_q      <= win_addr;
            data_q      <= win_data;
            ptr_q       <= ~grant_src;
            a_ready_q   <= (grant_src == SRC_A);
            b_ready_q   <= (grant_src == SRC_B);
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= win_addr;
            wr_src_q    <= grant_src;
            err_q       <= (win_addr >= NumRegsA);
            busy_q      <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          state_q <= HOLDOFF;
        end
        HOLDOFF: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  reg_arb_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we_i      (state_q == WRITE),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .regs_o    (regs)
`ifdef REG_READBACK_EN
    ,
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
`endif
  );

  assign bus.a_ready     = a_ready_q;
  assign bus.b_ready     = b_ready_q;
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;
  assign wr_src          = wr_src_q;
  assign err_addr        = err_q;
  assign busy            = busy_q;
  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_7_0];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_15_8];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_7_0];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_15_8];
  assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. Inputs change and outputs are checked
// on the falling clock edge. Readback checks are built with REG_READBACK_EN.
module tb_reg_write_arbiter;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  logic clk;
  logic rst;
  logic [DATA_W-1:0] r0, r1, r2, r3, r4;
  logic wr_strobe, wr_src, err_addr, busy;
  logic [ADDR_W-1:0] wr_addr;
`ifdef REG_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  reg_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  reg_write_arbiter #(
    .NUM_REGS (5),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr),
    .wr_src          (wr_src),
    .err_addr        (err_addr),
    .busy            (busy)
`ifdef REG_READBACK_EN
    ,
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, ".r0"}, 32'(r0), 32'(e0));
    chk({tag, ".r1"}, 32'(r1), 32'(e1));
    chk({tag, ".r2"}, 32'(r2), 32'(e2));
    chk({tag, ".r3"}, 32'(r3), 32'(e3));
    chk({tag, ".r4"}, 32'(r4), 32'(e4));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req_a(input logic v, input logic [6:0] a, input logic [7:0] d);
    bus_if.a_valid = v;
    bus_if.a_addr  = a;
    bus_if.a_data  = d;
  endtask

  task automatic req_b(input logic v, input logic [6:0] a, input logic [7:0] d);
    bus_if.b_valid = v;
    bus_if.b_addr  = a;
    bus_if.b_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    req_a(1'b0, 7'd0, 8'h00);
    req_b(1'b0, 7'd0, 8'h00);
`ifdef REG_READBACK_EN
    rd_addr = '0;
`endif
    tick();
    tick();

    // Reset state
    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.a_ready", 32'(bus_if.a_ready), 0);
    chk("reset.b_ready", 32'(bus_if.b_ready), 0);
    chk("reset.wr_strobe", 32'(wr_strobe), 0);
    chk("reset.err_addr", 32'(err_addr), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.wr_addr", 32'(wr_addr), 0);
    chk("reset.wr_src", 32'(wr_src), 0);
    rst = 1'b0;

    // A alone: addr 4 = 0x80
    req_a(1'b1, 7'd4, 8'h80);
    tick();
    chk("t1.a_ready", 32'(bus_if.a_ready), 1);
    chk("t1.b_ready", 32'(bus_if.b_ready), 0);
    chk("t1.wr_strobe", 32'(wr_strobe), 1);
    chk("t1.wr_addr", 32'(wr_addr), 4);
    chk("t1.wr_src", 32'(wr_src), 0);
    chk("t1.err_addr", 32'(err_addr), 0);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.pwm_early", 32'(r4), 0);
    req_a(1'b0, 7'd0, 8'h11);  // changed after sample: must be ignored
    tick();
    chk("t1.pwm", 32'(r4), 'h80);
    chk("t1.a_ready_off", 32'(bus_if.a_ready), 0);
    chk("t1.strobe_off", 32'(wr_strobe), 0);
    chk("t1.busy_holdoff", 32'(busy), 1);
    tick();
    chk("t1.busy_idle", 32'(busy), 0);

    // Fresh reset so the pointer is A, then contention on addr 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_regs("t2.reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    req_a(1'b1, 7'd0, 8'hAA);
    req_b(1'b1, 7'd0, 8'h55);
    tick();
    chk("t2.a_ready", 32'(bus_if.a_ready), 1);
    chk("t2.b_ready0", 32'(bus_if.b_ready), 0);
    chk("t2.wr_src_a", 32'(wr_src), 0);
    req_a(1'b0, 7'd0, 8'h00);
    tick();
    chk("t2.r0_aa", 32'(r0), 'hAA);
    chk("t2.b_ready1", 32'(bus_if.b_ready), 0);
    tick();
    chk("t2.b_ready2", 32'(bus_if.b_ready), 0);
    tick();
    chk("t2.b_ready", 32'(bus_if.b_ready), 1);
    chk("t2.a_ready_b", 32'(bus_if.a_ready), 0);
    chk("t2.wr_src_b", 32'(wr_src), 1);
    req_b(1'b0, 7'd0, 8'h00);
    tick();
    chk("t2.r0_55", 32'(r0), 'h55);
    tick();

    // B alone, then contention: pointer must be back at A
    req_b(1'b1, 7'd1, 8'h0F);
    tick();
    chk("t3.b_ready", 32'(bus_if.b_ready), 1);
    chk("t3.wr_src", 32'(wr_src), 1);
    req_b(1'b0, 7'd0, 8'h00);
    tick();
    tick();
    chk("t3.r1", 32'(r1), 'h0F);
    req_a(1'b1, 7'd2, 8'h21);
    req_b(1'b1, 7'd3, 8'h43);
    tick();
    chk("t3.a_first", 32'(bus_if.a_ready), 1);
    chk("t3.b_wait", 32'(bus_if.b_ready), 0);
    chk("t3.wr_addr2", 32'(wr_addr), 2);
    req_a(1'b0, 7'd0, 8'h00);
    tick();
    chk("t3.r2", 32'(r2), 'h21);
    chk("t3.r3_early", 32'(r3), 0);
    tick();
    tick();
    chk("t3.b_second", 32'(bus_if.b_ready), 1);
    chk("t3.wr_addr3", 32'(wr_addr), 3);
    req_b(1'b0, 7'd0, 8'h00);
    tick();
    chk("t3.r3", 32'(r3), 'h43);
    tick();

    // Out-of-range address
    req_a(1'b1, 7'd5, 8'hFF);
    tick();
    chk("t4.err_addr", 32'(err_addr), 1);
    chk("t4.a_ready", 32'(bus_if.a_ready), 1);
    chk("t4.wr_strobe", 32'(wr_strobe), 1);
    chk("t4.wr_addr", 32'(wr_addr), 5);
    req_a(1'b0, 7'd0, 8'h00);
    tick();
    chk("t4.err_off", 32'(err_addr), 0);
    chk_regs("t4", 8'h55, 8'h0F, 8'h21, 8'h43, 8'h00);
    tick();

    // Reset during B's WRITE cycle
    req_b(1'b1, 7'd3, 8'h12);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5.b_ready", 32'(bus_if.b_ready), 0);
    chk("t5.wr_strobe", 32'(wr_strobe), 0);
    chk("t5.busy", 32'(busy), 0);
    req_b(1'b0, 7'd0, 8'h00);
    tick();
    chk("t5.b_ready_later", 32'(bus_if.b_ready), 0);
    chk_regs("t5", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    req_a(1'b1, 7'd4, 8'h5A);
    tick();
    chk("t5.next_a_ready", 32'(bus_if.a_ready), 1);
    chk("t5.next_wr_src", 32'(wr_src), 0);
    req_a(1'b0, 7'd0, 8'h00);
    tick();
    chk("t5.pwm", 32'(r4), 'h5A);
    chk("t5.r3", 32'(r3), 0);
    tick();

`ifdef REG_READBACK_EN
    // Readback: old value during the write, new value one cycle later
    rd_addr = 7'd2;
    req_a(1'b1, 7'd2, 8'h3C);
    tick();
    req_a(1'b0, 7'd0, 8'h00);
    tick();
    chk("rb.old", 32'(rd_data), 0);
    tick();
    chk("rb.new", 32'(rd_data), 'h3C);
    rd_addr = 7'd9;
    tick();
    chk("rb.oob", 32'(rd_data), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
